plru_tree_manager: RTL and testbench

//  Per-set tree pseudo-LRU replacement engine for the set-associative LLC: holds NUM_WAYS-1 PLRU bits per set,

---
 rtl/plru_tree_manager.sv | 171 +++++++++++++++++
 tb/tb_plru_tree_manager.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/plru_tree_manager.sv
// Per-set tree pseudo-LRU engine: owns NUM_WAYS-1 bits per set, updates on HIT/FILL, returns victims.
// Build option: define PLRU_INVALID_FIRST_EN to prefer the lowest-index invalid way on FILL/PEEK.
module plru_tree_manager #(
    parameter  int NUM_WAYS = 8,
    parameter  int NUM_SETS = 64,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int PLRU_W   = NUM_WAYS - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [SET_W-1:0]    req_set,
    input  logic [WAY_W-1:0]    req_way,
    input  logic [NUM_WAYS-1:0] req_valid_mask,
    output logic                rsp_valid,
    output logic [WAY_W-1:0]    rsp_way,
    output logic [SET_W-1:0]    rsp_set,
    output logic                rsp_err,
    output logic                init_done
);
    localparam int STAGES = 1;

    typedef enum logic [1:0] {OP_HIT = 2'b00, OP_FILL = 2'b01, OP_PEEK = 2'b10, OP_RSV = 2'b11} op_e;
    typedef enum logic {ST_INIT, ST_RUN} state_e;

    typedef struct packed {
        op_e                 op;
        logic [SET_W-1:0]    set;
        logic [WAY_W-1:0]    way;
        logic [NUM_WAYS-1:0] mask;
    } req_t;

    // Heap-ordered tree: at level l the node on the path to w is (2^l-1) + (w >> (WAY_W-l)).
    function automatic logic [PLRU_W-1:0] tree_touch(input logic [PLRU_W-1:0] st,
                                                     input logic [WAY_W-1:0]  w);
        logic [PLRU_W-1:0] r;
        int idx, dir;
        r = st;
        for (int l = 0; l < WAY_W; l++) begin
            idx = (1 << l) - 1 + (int'(w) >> (WAY_W - l));
            dir = (int'(w) >> (WAY_W - 1 - l)) & 1;
            r   = (r & ~(PLRU_W'(1) << idx)) | (PLRU_W'(dir) << idx);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] tree_victim(input logic [PLRU_W-1:0] st);
        int node;
        node = 0;
        for (int l = 0; l < WAY_W; l++)
            node = 2 * node + 1 + ((((st >> node) & PLRU_W'(1)) == '0) ? 1 : 0);
        return WAY_W'(node - PLRU_W);
    endfunction

`ifdef PLRU_INVALID_FIRST_EN
    function automatic logic [WAY_W-1:0] first_invalid(input logic [NUM_WAYS-1:0] m);
        logic [WAY_W-1:0] w;
        w = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (((m >> i) & NUM_WAYS'(1)) == '0) w = WAY_W'(i);
        return w;
    endfunction
`endif

    logic [PLRU_W-1:0] mem [NUM_SETS];
    state_e            state_q, state_d;
    logic [SET_W-1:0]  sweep_q;
    logic [STAGES:0]   vld_pipe;
    logic              accept;
    req_t              req_in, s1_q;
    logic [PLRU_W-1:0] s1_st, nxt_st;
    logic [WAY_W-1:0]  victim, rsp_way_d;
    logic              wr_en, rsp_err_d;

    // Init sweep then run forever; only reset returns to INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) sweep_q <= sweep_q + SET_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        init_done = 1'b0;
        case (state_q)
            ST_INIT: if (sweep_q == SET_W'(NUM_SETS - 1)) state_d = ST_RUN;
            ST_RUN:  init_done = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    assign req_ready = init_done;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = vld_pipe[STAGES];

    always_comb begin
        req_in.op   = op_e'(req_op);
        req_in.set  = req_set;
        req_in.way  = req_way;
        req_in.mask = req_valid_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:0], accept};
    end

    // S1: capture request and set state; forward S2's result when both target the same set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_q  <= req_in;
            s1_st <= (vld_pipe[0] && (s1_q.set == req_set)) ? nxt_st : mem[req_set];
        end
    end

    // S2: victim, next state and response. Non-writing ops leave nxt_st equal to s1_st.
    always_comb begin
        victim = tree_victim(s1_st);
`ifdef PLRU_INVALID_FIRST_EN
        if (s1_q.mask != '1) victim = first_invalid(s1_q.mask);
`endif
        nxt_st    = s1_st;
        wr_en     = 1'b0;
        rsp_way_d = '0;
        rsp_err_d = 1'b0;
        case (s1_q.op)
            OP_HIT: begin
                nxt_st    = tree_touch(s1_st, s1_q.way);
                wr_en     = 1'b1;
                rsp_way_d = s1_q.way;
            end
            OP_FILL: begin
                nxt_st    = tree_touch(s1_st, victim);
                wr_en     = 1'b1;
                rsp_way_d = victim;
            end
            OP_PEEK: rsp_way_d = victim;
            default: rsp_err_d = 1'b1;
        endcase
    end

`ifndef PLRU_INVALID_FIRST_EN
    logic unused_mask;
    assign unused_mask = ^s1_q.mask;
`endif

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT)         mem[sweep_q]  <= '0;
        else if (vld_pipe[0] && wr_en) mem[s1_q.set] <= nxt_st;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_way <= '0;
            rsp_set <= '0;
            rsp_err <= 1'b0;
        end else if (vld_pipe[0]) begin
            rsp_way <= rsp_way_d;
            rsp_set <= s1_q.set;
            rsp_err <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_plru_tree_manager.sv
// Directed spec scenarios plus randomized traffic against a per-set tree model walked node by node.
module tb_plru_tree_manager;
    localparam int NW = 8;
    localparam int NS = 64;
    localparam int WW = 3;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [SW-1:0] req_set = '0;
    logic [WW-1:0] req_way = '0;
    logic [NW-1:0] req_valid_mask = '1;
    logic          rsp_valid;
    logic [WW-1:0] rsp_way;
    logic [SW-1:0] rsp_set;
    logic          rsp_err;
    logic          init_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int way;
        int set;
        int err;
        int cyc;
    } exp_t;
    exp_t exp_q[$];
    bit   tn[int];

    plru_tree_manager #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_set(req_set), .req_way(req_way), .req_valid_mask(req_valid_mask),
        .rsp_valid(rsp_valid), .rsp_way(rsp_way), .rsp_set(rsp_set),
        .rsp_err(rsp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < NS * (NW - 1); k++) tn[k] = 1'b0;
    endfunction

    function automatic void m_touch(input int s, input int w);
        int node;
        int d;
        node = 0;
        for (int l = WW - 1; l >= 0; l--) begin
            d = (w >> l) & 1;
            tn[s * (NW - 1) + node] = (d != 0);
            node = 2 * node + 1 + d;
        end
    endfunction

    function automatic int m_victim(input int s, input logic [NW-1:0] m);
        int node;
`ifndef PLRU_INVALID_FIRST_EN
        logic [NW-1:0] unused_m;
        unused_m = m;
`else
        for (int i = 0; i < NW; i++)
            if (((m >> i) & 1) == 0) return i;
`endif
        node = 0;
        while (node < NW - 1) node = 2 * node + 1 + (tn[s * (NW - 1) + node] ? 0 : 1);
        return node - (NW - 1);
    endfunction

    // want >= 0 overrides the model with a value quoted from the spec scenarios.
    task automatic issue(input logic [1:0] op, input int s, input int w, input logic [NW-1:0] m,
                         input int want);
        exp_t e;
        int   v;
        @(negedge clk);
        chk("req_ready", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_set = SW'(s); req_way = WW'(w); req_valid_mask = m;
        e.err = 0;
        case (op)
            2'b00: begin e.way = w; m_touch(s, w); end
            2'b01: begin v = m_victim(s, m); m_touch(s, v); e.way = v; end
            2'b10: e.way = m_victim(s, m);
            default: begin e.way = 0; e.err = 1; end
        endcase
        if (want >= 0) e.way = want;
        e.set = s;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep_cycles", n, 64);
        chk("ready_after_init", req_ready, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_way"}, rsp_way, 0);
        chk({tag, "_rsp_set"}, rsp_set, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_way", rsp_way, e.way);
                chk("rsp_set", rsp_set, e.set);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_latency", cyc, e.cyc + 2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int            r;
        logic [1:0]    op;
        logic [NW-1:0] mk;
        int            s;
        m_reset();
        #1;
        chk_reset_vals("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_init();

        issue(2'b10, 5, 0, 8'hFF, 7);
        issue(2'b00, 3, 7, 8'hFF, -1);
        issue(2'b10, 3, 0, 8'hFF, 3);
        issue(2'b00, 9, 7, 8'hFF, -1);
        issue(2'b00, 9, 3, 8'hFF, -1);
        issue(2'b10, 9, 0, 8'hFF, 5);
`ifdef PLRU_INVALID_FIRST_EN
        issue(2'b01, 2, 0, 8'hFB, 2);
        issue(2'b10, 2, 0, 8'hFF, 7);
`else
        issue(2'b01, 2, 0, 8'hFB, 7);
        issue(2'b10, 2, 0, 8'hFF, 3);
`endif
        issue(2'b00, 4, 7, 8'hFF, -1);
        issue(2'b11, 4, 5, 8'hFF, -1);
        issue(2'b10, 4, 0, 8'hFF, 3);
        drain();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) idle();
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            mk = ($urandom_range(0, 2) == 0) ? NW'($urandom) : 8'hFF;
            s  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NS - 1) : $urandom_range(0, 7);
            issue(op, s, $urandom_range(0, NW - 1), mk, -1);
        end
        drain();

        // Reset with one op in S1 and another being presented: both must vanish.
        issue(2'b01, 6, 0, 8'hFF, -1);
        issue(2'b00, 6, 2, 8'hFF, -1);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        m_reset();
        #1;
        chk_reset_vals("midop");
        repeat (3) @(negedge clk);
        chk("held_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        wait_init();

        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rerun");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midsweep");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        issue(2'b10, 9, 0, 8'hFF, 7);
        issue(2'b10, 3, 0, 8'hFF, 7);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
